// File: rtl/wallace_mult_arbiter.sv
// Round-robin sequencer sharing one combinational N x N multiplier among NUM_REQ requesters.
// Optional build macro WALLACE_ARB_ZERO_SKIP_EN: zero operands bypass EXEC and return 0 one cycle earlier.
module wallace_mult_arbiter #(
    parameter int N       = 8,
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*N-1:0] req_a,
    input  logic [NUM_REQ*N-1:0] req_b,
    output logic [N-1:0]         mul_a,
    output logic [N-1:0]         mul_b,
    input  logic [2*N-1:0]       mul_product,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*N-1:0]       rsp_product,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [N-1:0]    mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [2*N-1:0]  rsp_product_q, rsp_product_d;
    logic            rsp_valid_q, rsp_valid_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_id;
    logic [N-1:0]    grant_a, grant_b;

    // Scan ptr, ptr+1, ... wrapping at NUM_REQ (which need not be a power of two).
    always_comb begin
        int cand;
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!grant_found && req_valid[ID_W'(cand)]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(cand);
            end
        end
    end

    assign grant_a = req_a[int'(grant_id)*N +: N];
    assign grant_b = req_b[int'(grant_id)*N +: N];

`ifdef WALLACE_ARB_ZERO_SKIP_EN
    logic op_zero;
    assign op_zero = (grant_a == '0) || (grant_b == '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d = EXEC;
`ifdef WALLACE_ARB_ZERO_SKIP_EN
                    if (op_zero) state_d = RESP;
`endif
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        ptr_d         = ptr_q;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        rsp_id_d      = rsp_id_q;
        rsp_product_d = rsp_product_q;
        rsp_valid_d   = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_id] = 1'b1;
                    mul_a_d             = grant_a;
                    mul_b_d             = grant_b;
                    rsp_id_d            = grant_id;
`ifdef WALLACE_ARB_ZERO_SKIP_EN
                    if (op_zero) begin
                        rsp_product_d = '0;
                        rsp_valid_d   = 1'b1;
                    end
`endif
                end
            end
            EXEC: begin
                rsp_product_d = mul_product;
                rsp_valid_d   = 1'b1;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = (rsp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset discards any in-flight operands and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            rsp_id_q      <= '0;
            rsp_product_q <= '0;
            rsp_valid_q   <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            rsp_id_q      <= rsp_id_d;
            rsp_product_q <= rsp_product_d;
            rsp_valid_q   <= rsp_valid_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_product = rsp_product_q;
    assign rsp_valid   = rsp_valid_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_wallace_mult_arbiter.sv
// Directed bench for wallace_mult_arbiter: transaction-level model compared every cycle,
// plus literal expectations on responses per scenario.
module tb_wallace_mult_arbiter;
    localparam int N       = 8;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int P       = 2 * N;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a, req_b;
    logic [N-1:0]         mul_a, mul_b;
    logic [P-1:0]         mul_product;
    logic                 rsp_valid, rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [P-1:0]         rsp_product;
    logic                 busy;

    int n_chk  = 0;
    int n_pass = 0;

    wallace_mult_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_product(rsp_product), .busy(busy)
    );

    // The shared multiplier itself.
    assign mul_product = P'(mul_a) * P'(mul_b);

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- transaction-level model ----------------
    logic               m_live = 1'b0;
    logic               m_busy = 1'b0;
    logic               m_rsp_v = 1'b0;
    int                 m_ptr = 0;
    int                 m_id = 0;
    logic [N-1:0]       m_a = '0, m_b = '0;
    logic [P-1:0]       m_prod = '0;
    logic [NUM_REQ-1:0] m_acc = '0;
    int                 m_win;
    logic [NUM_REQ-1:0] exp_rdy;

    function automatic int winner(input logic [NUM_REQ-1:0] v, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    always_comb m_win = winner(req_valid, m_ptr);

    always_comb begin
        exp_rdy = '0;
        if (!m_busy && m_win >= 0) exp_rdy[m_win] = 1'b1;
    end

    always @(posedge clk) begin
        m_acc <= '0;
        if (rst) begin
            m_live <= 1'b1; m_busy <= 1'b0; m_rsp_v <= 1'b0; m_ptr <= 0;
            m_id <= 0; m_a <= '0; m_b <= '0; m_prod <= '0;
        end else if (!m_busy) begin
            if (m_win >= 0) begin
                m_acc  <= NUM_REQ'(1) << m_win;
                m_busy <= 1'b1;
                m_id   <= m_win;
                m_a    <= req_a[m_win*N +: N];
                m_b    <= req_b[m_win*N +: N];
`ifdef WALLACE_ARB_ZERO_SKIP_EN
                if (req_a[m_win*N +: N] == 0 || req_b[m_win*N +: N] == 0) begin
                    m_rsp_v <= 1'b1;
                    m_prod  <= '0;
                end
`endif
            end
        end else if (!m_rsp_v) begin
            m_rsp_v <= 1'b1;
            m_prod  <= P'(m_a) * P'(m_b);
        end else if (rsp_ready) begin
            m_rsp_v <= 1'b0;
            m_busy  <= 1'b0;
            m_ptr   <= (m_id + 1) % NUM_REQ;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        #3;
        if (m_live) begin
            chk("cmp_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("cmp_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            chk("cmp_busy", 32'(busy), 32'(m_busy));
            chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
            chk("cmp_mul_a", 32'(mul_a), 32'(m_a));
            chk("cmp_mul_b", 32'(mul_b), 32'(m_b));
            chk("cmp_rsp_id", 32'(rsp_id), 32'(m_id));
            chk("cmp_rsp_product", 32'(rsp_product), 32'(m_prod));
        end
    end

    // Log of responses actually delivered by the DUT.
    int       log_id[$];
    int       log_p[$];
    always @(posedge clk) begin
        if (!rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            log_id.push_back(int'(rsp_id));
            log_p.push_back(int'(rsp_product));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        req_valid = req_valid & ~m_acc;   // requester drops once accepted
        #1;
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((req_valid != 0 || m_busy) && c < 200) begin
            tick();
            c++;
        end
        chk(name, 32'(c < 200), 32'd1);
    endtask

    task automatic set_op(input int k, input logic [N-1:0] a, input logic [N-1:0] b);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx, input int id, input int prod);
        if (idx < log_id.size()) begin
            chk({name, "_id"}, 32'(log_id[idx]), 32'(id));
            chk({name, "_prod"}, 32'(log_p[idx]), 32'(prod));
        end else begin
            chk({name, "_present"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int base;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick(); tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_rsp_product", 32'(rsp_product), 32'd0);
        rst = 1'b0;
        tick();

        // Single request on requester 2
        set_op(2, 8'hFF, 8'hFF);
        req_valid = 4'b0100;
        #1;
        chk("t1_ready", 32'(req_ready), 32'b0100);
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_not_yet", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd2);
        chk("t1_rsp_product", 32'(rsp_product), 32'hFE01);
        tick();
        chk("t1_idle", 32'(busy), 32'd0);

        // All four at once, fresh pointer
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) set_op(k, N'((k + 1) * 8'h11), 8'h0F);
        base = log_id.size();
        req_valid = 4'b1111;
        drain("t2_drain");
        chk_log("t2_r0", base + 0, 0, 16'h00FF);
        chk_log("t2_r1", base + 1, 1, 16'h01FE);
        chk_log("t2_r2", base + 2, 2, 16'h02FD);
        chk_log("t2_r3", base + 3, 3, 16'h03FC);

        // Rotation after serving id 1
        do_reset();
        base = log_id.size();
        set_op(1, 8'd3, 8'd5);
        req_valid = 4'b0010;
        drain("t3_drain_a");
        set_op(0, 8'd2, 8'd7);
        req_valid = 4'b0011;
        drain("t3_drain_b");
        chk_log("t3_r0", base + 0, 1, 15);
        chk_log("t3_r1", base + 1, 0, 14);
        chk_log("t3_r2", base + 2, 1, 15);

        // Backpressure in RESP
        base = log_id.size();
        set_op(3, 8'hF0, 8'h0F);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        tick();
        tick();
        req_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
            chk("t4_hold_id", 32'(rsp_id), 32'd3);
            chk("t4_hold_prod", 32'(rsp_product), 32'h0E10);
            chk("t4_no_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t4_handshake", 32'(rsp_valid), 32'd0);
        drain("t4_drain");
        chk_log("t4_r0", base + 0, 3, 16'h0E10);
        chk_log("t4_r1", base + 1, 0, 14);

        // Reset while in EXEC (pointer is 1 here)
        set_op(2, 8'd9, 8'd9);
        set_op(3, 8'd1, 8'd1);
        req_valid = 4'b0100;
        tick();
        chk("t5_in_exec", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_mul_a", 32'(mul_a), 32'd0);
        chk("t5_mul_b", 32'(mul_b), 32'd0);
        chk("t5_rsp_id", 32'(rsp_id), 32'd0);
        chk("t5_rsp_product", 32'(rsp_product), 32'd0);
        rst = 1'b0;
        base = log_id.size();
        req_valid = 4'b1001;
        drain("t5_drain");
        chk("t5_count", 32'(log_id.size() - base), 32'd2);
        chk_log("t5_r0", base + 0, 0, 14);
        chk_log("t5_r1", base + 1, 3, 1);

        // Zero operand
        set_op(1, 8'h00, 8'h7F);
        req_valid = 4'b0010;
        tick();
        chk("t6_mul_b", 32'(mul_b), 32'h7F);
`ifdef WALLACE_ARB_ZERO_SKIP_EN
        chk("t6_early_valid", 32'(rsp_valid), 32'd1);
        chk("t6_prod", 32'(rsp_product), 32'd0);
`else
        chk("t6_not_yet", 32'(rsp_valid), 32'd0);
        tick();
        chk("t6_valid", 32'(rsp_valid), 32'd1);
        chk("t6_prod", 32'(rsp_product), 32'd0);
`endif
        drain("t6_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
